// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1 slice: OPMODE bit positions, X/Z mux
// select encodings and the attribute strings for CARRYINSEL / B_INPUT.
package dsp48a1_pkg;

   localparam int OPM_X_LO      = 0;
   localparam int OPM_Z_LO      = 2;
   localparam int OPM_PREADD_EN = 4;
   localparam int OPM_CIN       = 5;
   localparam int OPM_PRESUB    = 6;
   localparam int OPM_POSTSUB   = 7;

   typedef enum logic [1:0] {
      X_ZERO = 2'b00,
      X_M    = 2'b01,
      X_P    = 2'b10,
      X_DAB  = 2'b11
   } xsel_e;

   typedef enum logic [1:0] {
      Z_ZERO = 2'b00,
      Z_PCIN = 2'b01,
      Z_P    = 2'b10,
      Z_C    = 2'b11
   } zsel_e;

   // Attribute strings are held right-justified in a fixed 8-character field
   localparam int STRW = 64;
   localparam logic [STRW-1:0] CIS_OPMODE5 = "OPMODE5";
   localparam logic [STRW-1:0] CIS_CARRYIN = "CARRYIN";
   localparam logic [STRW-1:0] BIN_DIRECT  = "DIRECT";
   localparam logic [STRW-1:0] BIN_CASCADE = "CASCADE";

endpackage

// File: rtl/dsp48a1_if.sv
// Data/control bundle of the DSP48A1 slice: clock enables, operands,
// cascade ports and results. Clock and per-stage resets stay outside.
interface dsp48a1_if;
   logic        cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode;
   logic [17:0] a, b, d, bcin;
   logic [47:0] c, pcin;
   logic        carryin;
   logic [7:0]  opmode;
   logic [17:0] bcout;
   logic [35:0] m;
   logic [47:0] p, pcout;
   logic        carryout, carryoutf;

   modport master (
      output cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode,
      output a, b, d, bcin, c, pcin, carryin, opmode,
      input  bcout, m, p, pcout, carryout, carryoutf
   );

   modport slave (
      input  cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode,
      input  a, b, d, bcin, c, pcin, carryin, opmode,
      output bcout, m, p, pcout, carryout, carryoutf
   );
endinterface

// File: rtl/dsp48a1_reg_mux.sv
// Optional pipeline register with clock enable and reset, or a straight
// wire when REG=0 (CE/RST then have no effect).
module dsp_reg_mux #(
   parameter int WIDTH        = 18,
   parameter int RSTTYPE_SYNC = 1,
   parameter int REG          = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ce,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (REG != 0) begin : g_reg
         logic [WIDTH-1:0] r_q;
         if (RSTTYPE_SYNC != 0) begin : g_sync
            always_ff @(posedge i_clk) begin
               if (i_rst)     r_q <= '0;
               else if (i_ce) r_q <= i_d;
            end
         end else begin : g_async
            always_ff @(posedge i_clk or posedge i_rst) begin
               if (i_rst)     r_q <= '0;
               else if (i_ce) r_q <= i_d;
            end
         end
         assign o_q = r_q;
      end else begin : g_bypass
         assign o_q = i_d;
         wire w_unused = ^{i_clk, i_rst, i_ce};
      end
   endgenerate

endmodule

// File: rtl/dsp48a1.sv
// Spartan-6 style DSP48A1 slice: D+/-B pre-adder, 18x18 unsigned multiplier,
// 48-bit post-adder with B/P cascade. Define DSP48A1_BCIN_CASCADE_EN to honour B_INPUT="CASCADE".
module dsp48a1
   import dsp48a1_pkg::*;
#(
   parameter int A0REG       = 0,
   parameter int A1REG       = 1,
   parameter int B0REG       = 0,
   parameter int B1REG       = 1,
   parameter int CREG        = 1,
   parameter int DREG        = 1,
   parameter int MREG        = 1,
   parameter int PREG        = 1,
   parameter int OPMODEREG   = 1,
   parameter int CARRYINREG  = 1,
   parameter int CARRYOUTREG = 1,
   parameter logic [STRW-1:0] CARRYINSEL = CIS_OPMODE5,
   parameter logic [STRW-1:0] B_INPUT    = BIN_DIRECT
) (
   input  logic i_clk,
   input  logic i_rsta,
   input  logic i_rstb,
   input  logic i_rstc,
   input  logic i_rstd,
   input  logic i_rstm,
   input  logic i_rstp,
   input  logic i_rstcarryin,
   input  logic i_rstopmode,
   dsp48a1_if.slave bus
);

   // Anything other than "CARRYIN" falls back to OPMODE[5]
   localparam bit USE_CIN_PORT = (CARRYINSEL == CIS_CARRYIN);

   logic [7:0]  w_opm;
   logic [17:0] w_a0, w_a1, w_b0_in, w_b0, w_b1_in, w_b1, w_d, w_preadd;
   logic [35:0] w_mult, w_m;
   logic [47:0] w_c, w_x, w_z, w_p;
   logic [48:0] w_post;
   logic        w_cyi_in, w_cyi, w_cyo;

   dsp_reg_mux #(.WIDTH(8), .RSTTYPE_SYNC(1), .REG(OPMODEREG)) u_opm (
      .i_clk, .i_rst(i_rstopmode), .i_ce(bus.ceopmode), .i_d(bus.opmode), .o_q(w_opm));

   dsp_reg_mux #(.WIDTH(18), .RSTTYPE_SYNC(1), .REG(A0REG)) u_a0 (
      .i_clk, .i_rst(i_rsta), .i_ce(bus.cea), .i_d(bus.a), .o_q(w_a0));
   dsp_reg_mux #(.WIDTH(18), .RSTTYPE_SYNC(1), .REG(A1REG)) u_a1 (
      .i_clk, .i_rst(i_rsta), .i_ce(bus.cea), .i_d(w_a0), .o_q(w_a1));

`ifdef DSP48A1_BCIN_CASCADE_EN
   assign w_b0_in = (B_INPUT == BIN_CASCADE) ? bus.bcin : bus.b;
`else
   assign w_b0_in = bus.b;
   wire w_unused_bcin = ^{bus.bcin, B_INPUT};
`endif

   dsp_reg_mux #(.WIDTH(18), .RSTTYPE_SYNC(1), .REG(B0REG)) u_b0 (
      .i_clk, .i_rst(i_rstb), .i_ce(bus.ceb), .i_d(w_b0_in), .o_q(w_b0));
   dsp_reg_mux #(.WIDTH(18), .RSTTYPE_SYNC(1), .REG(DREG)) u_d (
      .i_clk, .i_rst(i_rstd), .i_ce(bus.ced), .i_d(bus.d), .o_q(w_d));

   // Pre-adder wraps mod 2^18 by construction of the 18-bit result
   assign w_preadd = w_opm[OPM_PRESUB] ? (w_d - w_b0) : (w_d + w_b0);
   assign w_b1_in  = w_opm[OPM_PREADD_EN] ? w_preadd : w_b0;

   dsp_reg_mux #(.WIDTH(18), .RSTTYPE_SYNC(1), .REG(B1REG)) u_b1 (
      .i_clk, .i_rst(i_rstb), .i_ce(bus.ceb), .i_d(w_b1_in), .o_q(w_b1));

   assign w_mult = {18'd0, w_a1} * {18'd0, w_b1};

   dsp_reg_mux #(.WIDTH(36), .RSTTYPE_SYNC(1), .REG(MREG)) u_m (
      .i_clk, .i_rst(i_rstm), .i_ce(bus.cem), .i_d(w_mult), .o_q(w_m));
   dsp_reg_mux #(.WIDTH(48), .RSTTYPE_SYNC(1), .REG(CREG)) u_c (
      .i_clk, .i_rst(i_rstc), .i_ce(bus.cec), .i_d(bus.c), .o_q(w_c));

   assign w_cyi_in = USE_CIN_PORT ? bus.carryin : w_opm[OPM_CIN];

   dsp_reg_mux #(.WIDTH(1), .RSTTYPE_SYNC(1), .REG(CARRYINREG)) u_cyi (
      .i_clk, .i_rst(i_rstcarryin), .i_ce(bus.cecarryin), .i_d(w_cyi_in), .o_q(w_cyi));

   always_comb begin
      w_x = '0;
      case (xsel_e'(w_opm[OPM_X_LO +: 2]))
         X_ZERO:  w_x = '0;
         X_M:     w_x = {12'd0, w_m};
         X_P:     w_x = w_p;
         X_DAB:   w_x = {w_d[11:0], w_a1, w_b1};
         default: w_x = '0;
      endcase
   end

   always_comb begin
      w_z = '0;
      case (zsel_e'(w_opm[OPM_Z_LO +: 2]))
         Z_ZERO:  w_z = '0;
         Z_PCIN:  w_z = bus.pcin;
         Z_P:     w_z = w_p;
         Z_C:     w_z = w_c;
         default: w_z = '0;
      endcase
   end

   // 49-bit result: bit 48 is the carry on add and the borrow on subtract
   assign w_post = w_opm[OPM_POSTSUB]
                 ? ({1'b0, w_z} - ({1'b0, w_x} + {48'd0, w_cyi}))
                 : ({1'b0, w_z} + {1'b0, w_x} + {48'd0, w_cyi});

   dsp_reg_mux #(.WIDTH(48), .RSTTYPE_SYNC(1), .REG(PREG)) u_p (
      .i_clk, .i_rst(i_rstp), .i_ce(bus.cep), .i_d(w_post[47:0]), .o_q(w_p));
   dsp_reg_mux #(.WIDTH(1), .RSTTYPE_SYNC(1), .REG(CARRYOUTREG)) u_cyo (
      .i_clk, .i_rst(i_rstcarryin), .i_ce(bus.cecarryin), .i_d(w_post[48]), .o_q(w_cyo));

   assign bus.bcout     = w_b1;
   assign bus.m         = w_m;
   assign bus.p         = w_p;
   assign bus.pcout     = w_p;
   assign bus.carryout  = w_cyo;
   assign bus.carryoutf = w_cyo;

endmodule

// File: tb/tb_dsp48a1.sv
// Self-checking bench for dsp48a1 (default parameters): directed vectors,
// randomized operands against a settled-value arithmetic model, latency, accumulate and CE/RST.
module tb_dsp48a1;

   logic clk = 1'b0;
   logic rsta, rstb, rstc, rstd, rstm, rstp, rstcarryin, rstopmode;
   int   checks = 0;
   int   errors = 0;

   localparam longint unsigned TWO48 = 64'h1_0000_0000_0000;

   always #5 clk = ~clk;

   dsp48a1_if bus();

   dsp48a1 dut (
      .i_clk(clk), .i_rsta(rsta), .i_rstb(rstb), .i_rstc(rstc), .i_rstd(rstd),
      .i_rstm(rstm), .i_rstp(rstp), .i_rstcarryin(rstcarryin), .i_rstopmode(rstopmode),
      .bus(bus)
   );

   // Settled outputs for constant inputs, straight from the arithmetic rules.
   // pfb stands in for P wherever a mux selects the feedback path.
   function automatic void model(input logic [7:0] op, input logic [17:0] a, b, d,
                                 input logic [47:0] c, pcin, pfb,
                                 output logic [17:0] e_bc, output logic [35:0] e_m,
                                 output logic [47:0] e_p, output logic e_co);
      longint unsigned pre, b1, mm, x, z, cin, s;
      pre = op[6] ? (64'(d) + 64'd262144 - 64'(b)) % 64'd262144
                  : (64'(d) + 64'(b)) % 64'd262144;
      b1  = op[4] ? pre : 64'(b);
      mm  = 64'(a) * b1;
      case (op[1:0])
         2'd0:    x = 0;
         2'd1:    x = mm;
         2'd2:    x = 64'(pfb);
         default: x = (64'(d[11:0]) << 36) + (64'(a) << 18) + b1;
      endcase
      case (op[3:2])
         2'd0:    z = 0;
         2'd1:    z = 64'(pcin);
         2'd2:    z = 64'(pfb);
         default: z = 64'(c);
      endcase
      cin = 64'(op[5]);
      if (op[7]) begin
         e_co = (z < x + cin);
         s    = (z + TWO48 - (x + cin)) % TWO48;
      end else begin
         s    = z + x + cin;
         e_co = (s >= TWO48);
         s    = s % TWO48;
      end
      e_p  = s[47:0];
      e_bc = b1[17:0];
      e_m  = mm[35:0];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rst(input logic v);
      rsta = v; rstb = v; rstc = v; rstd = v; rstm = v; rstp = v; rstcarryin = v; rstopmode = v;
   endtask

   task automatic set_ce(input logic v);
      bus.cea = v; bus.ceb = v; bus.cec = v; bus.ced = v;
      bus.cem = v; bus.cep = v; bus.cecarryin = v; bus.ceopmode = v;
   endtask

   task automatic drive(input logic [7:0] op, input logic [17:0] a, b, d, input logic [47:0] c, pcin);
      bus.opmode = op; bus.a = a; bus.b = b; bus.d = d; bus.c = c; bus.pcin = pcin;
   endtask

   task automatic test_reset();
      drive(8'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
            48'({$urandom, $urandom}), 48'({$urandom, $urandom}));
      bus.cea = 1'($urandom); bus.ceb = 1'($urandom); bus.cec = 1'($urandom); bus.ced = 1'($urandom);
      bus.cem = 1'($urandom); bus.cep = 1'($urandom); bus.cecarryin = 1'($urandom);
      bus.ceopmode = 1'($urandom); bus.carryin = 1'($urandom); bus.bcin = 18'($urandom);
      set_rst(1'b1);
      tick(1);
      checks++; if (bus.p !== 48'd0)     begin errors++; $display("FAIL reset_p got %h want 0", bus.p); end
      checks++; if (bus.pcout !== 48'd0) begin errors++; $display("FAIL reset_pcout got %h want 0", bus.pcout); end
      checks++; if (bus.m !== 36'd0)     begin errors++; $display("FAIL reset_m got %h want 0", bus.m); end
      checks++; if (bus.bcout !== 18'd0) begin errors++; $display("FAIL reset_bcout got %h want 0", bus.bcout); end
      checks++; if (bus.carryout !== 1'b0)  begin errors++; $display("FAIL reset_carryout got %b want 0", bus.carryout); end
      checks++; if (bus.carryoutf !== 1'b0) begin errors++; $display("FAIL reset_carryoutf got %b want 0", bus.carryoutf); end
      set_rst(1'b0);
      set_ce(1'b1);
      bus.carryin = 1'b0;
   endtask

   task automatic test_spec_vectors();
      logic [17:0] ebc; logic [35:0] em; logic [47:0] ep; logic eco;
      // pre-subtract into B1, multiply, subtract M from C
      drive(8'hDD, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0);
      tick(4);
      model(8'hDD, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 48'd0, ebc, em, ep, eco);
      checks++;
      if ({bus.bcout, bus.m, bus.p, bus.pcout, bus.carryout} !== {ebc, em, ep, ep, eco}) begin
         errors++;
         $display("FAIL vec_dd got bc=%h m=%h p=%h pc=%h co=%b want bc=%h m=%h p=%h co=%b",
                  bus.bcout, bus.m, bus.p, bus.pcout, bus.carryout, ebc, em, ep, eco);
      end
      drive(8'h10, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0);
      tick(3);
      model(8'h10, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 48'd0, ebc, em, ep, eco);
      checks++;
      if ({bus.bcout, bus.m, bus.p, bus.pcout, bus.carryout} !== {ebc, em, ep, ep, eco}) begin
         errors++;
         $display("FAIL vec_10 got bc=%h m=%h p=%h co=%b want bc=%h m=%h p=%h co=%b",
                  bus.bcout, bus.m, bus.p, bus.carryout, ebc, em, ep, eco);
      end
      // P + P from P = 0 keeps P at zero while B/M follow the inputs
      drive(8'h0A, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0);
      tick(3);
      model(8'h0A, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 48'd0, ebc, em, ep, eco);
      checks++;
      if ({bus.bcout, bus.m, bus.p} !== {ebc, em, ep}) begin
         errors++;
         $display("FAIL vec_0a got bc=%h m=%h p=%h want bc=%h m=%h p=%h", bus.bcout, bus.m, bus.p, ebc, em, ep);
      end
      drive(8'h0A, 18'd5, 18'd6, 18'd25, 48'd350, 48'd0);
      tick(3);
      model(8'h0A, 18'd5, 18'd6, 18'd25, 48'd350, 48'd0, 48'd0, ebc, em, ep, eco);
      checks++;
      if ({bus.bcout, bus.m, bus.p} !== {ebc, em, ep}) begin
         errors++;
         $display("FAIL vec_0a_b got bc=%h m=%h p=%h want bc=%h m=%h p=%h", bus.bcout, bus.m, bus.p, ebc, em, ep);
      end
      // concatenation path with OPMODE[5] carry-in
      drive(8'h33, 18'd0, 18'd2, 18'd1, 48'd350, 48'd0);
      tick(4);
      model(8'h33, 18'd0, 18'd2, 18'd1, 48'd350, 48'd0, 48'd0, ebc, em, ep, eco);
      checks++;
      if (bus.p !== ep) begin errors++; $display("FAIL vec_33 got p=%h want p=%h", bus.p, ep); end
      // C + M overflows 48 bits exactly to zero
      drive(8'h0D, 18'd1, 18'd1, 18'd1, 48'hFFFF_FFFF_FFFF, 48'd0);
      tick(4);
      model(8'h0D, 18'd1, 18'd1, 18'd1, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0, ebc, em, ep, eco);
      checks++;
      if ({bus.p, bus.carryout, bus.carryoutf} !== {ep, eco, eco}) begin
         errors++;
         $display("FAIL vec_0d got p=%h co=%b cof=%b want p=%h co=%b", bus.p, bus.carryout, bus.carryoutf, ep, eco);
      end
   endtask

   task automatic test_arith();
      logic [7:0]  t_op [5] = '{8'h51, 8'h11, 8'h8D, 8'h2D, 8'h37};
      logic [17:0] t_a  [5] = '{18'd3, 18'd1, 18'd1, 18'h3FFFF, 18'h1234};
      logic [17:0] t_b  [5] = '{18'd1, 18'h3FFFF, 18'd1, 18'h3FFFF, 18'h2345};
      logic [17:0] t_d  [5] = '{18'd0, 18'h3FFFF, 18'd0, 18'd0, 18'h0ABC};
      logic [47:0] t_c  [5] = '{48'd0, 48'd0, 48'd0, 48'hFFFF_FFFF_FFFF, 48'd0};
      logic [7:0]  op; logic [17:0] a, b, d; logic [47:0] c, pcin;
      logic [17:0] ebc; logic [35:0] em; logic [47:0] ep; logic eco;
      for (int i = 0; i < 25; i++) begin
         if (i < 5) begin
            op = t_op[i]; a = t_a[i]; b = t_b[i]; d = t_d[i]; c = t_c[i];
            pcin = 48'h8000_0000_0001;
         end else begin
            op = 8'($urandom);
            if (op[1:0] == 2'b10) op[1:0] = 2'b11;
            if (op[3:2] == 2'b10) op[3:2] = 2'b01;
            a = 18'($urandom); b = 18'($urandom); d = 18'($urandom);
            c = 48'({$urandom, $urandom}); pcin = 48'({$urandom, $urandom});
         end
         drive(op, a, b, d, c, pcin);
         bus.carryin = 1'($urandom);
         tick(4);
         model(op, a, b, d, c, pcin, 48'd0, ebc, em, ep, eco);
         checks++;
         if ({bus.bcout, bus.m, bus.p, bus.pcout, bus.carryout, bus.carryoutf} !== {ebc, em, ep, ep, eco, eco}) begin
            errors++;
            $display("FAIL arith[%0d] op=%h got bc=%h m=%h p=%h pc=%h co=%b cof=%b want bc=%h m=%h p=%h co=%b",
                     i, op, bus.bcout, bus.m, bus.p, bus.pcout, bus.carryout, bus.carryoutf, ebc, em, ep, eco);
         end
      end
   endtask

   task automatic test_latency();
      logic [17:0] a, b, d; logic [47:0] c;
      logic [17:0] ebc; logic [35:0] em; logic [47:0] e_old, e_new; logic eco;
      a = 18'($urandom) | 18'd1; b = 18'($urandom) | 18'd1; d = 18'($urandom); c = 48'({$urandom, $urandom});
      // A -> P
      drive(8'h01, a, b, d, c, 48'd0); tick(5);
      model(8'h01, a, b, d, c, 48'd0, 48'd0, ebc, em, e_old, eco);
      model(8'h01, a + 18'd1, b, d, c, 48'd0, 48'd0, ebc, em, e_new, eco);
      bus.a = a + 18'd1; tick(2);
      checks++; if (bus.p !== e_old) begin errors++; $display("FAIL lat_a_early got %h want %h", bus.p, e_old); end
      tick(1);
      checks++; if (bus.p !== e_new) begin errors++; $display("FAIL lat_a got %h want %h", bus.p, e_new); end
      // C -> P
      drive(8'h0C, a, b, d, c, 48'd0); tick(5);
      bus.c = ~c; tick(1);
      checks++; if (bus.p !== c)  begin errors++; $display("FAIL lat_c_early got %h want %h", bus.p, c); end
      tick(1);
      checks++; if (bus.p !== ~c) begin errors++; $display("FAIL lat_c got %h want %h", bus.p, ~c); end
      // D -> P through the pre-adder
      drive(8'h11, a, b, d, c, 48'd0); tick(5);
      model(8'h11, a, b, d, c, 48'd0, 48'd0, ebc, em, e_old, eco);
      model(8'h11, a, b, d ^ 18'd1, c, 48'd0, 48'd0, ebc, em, e_new, eco);
      bus.d = d ^ 18'd1; tick(3);
      checks++; if (bus.p !== e_old) begin errors++; $display("FAIL lat_d_early got %h want %h", bus.p, e_old); end
      tick(1);
      checks++; if (bus.p !== e_new) begin errors++; $display("FAIL lat_d got %h want %h", bus.p, e_new); end
   endtask

   task automatic test_accumulate();
      logic [17:0] a, b; longint unsigned prod, exp_p;
      a = 18'($urandom); b = 18'($urandom);
      prod = 64'(a) * 64'(b);
      drive(8'h01, a, b, 18'd0, 48'd0, 48'd0); tick(5);
      bus.opmode = 8'h09;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         exp_p = (64'(k) * prod) % TWO48;
         checks++;
         if (bus.p !== exp_p[47:0]) begin
            errors++; $display("FAIL accum[%0d] got %h want %h", k, bus.p, exp_p[47:0]);
         end
      end
   endtask

   task automatic test_ce();
      logic [17:0] a1, a2, a3, b1, b3;
      logic [17:0] ebc; logic [35:0] em_hold, em; logic [47:0] ep_hold, ep; logic eco;
      a1 = 18'($urandom) | 18'd1; b1 = 18'($urandom) | 18'd1;
      a2 = a1 ^ 18'h00F0; a3 = a1 ^ 18'h0F00; b3 = b1 ^ 18'h0055;
      drive(8'h01, a1, b1, 18'd0, 48'd0, 48'd0); tick(5);
      model(8'h01, a1, b1, 18'd0, 48'd0, 48'd0, 48'd0, ebc, em, ep_hold, eco);
      bus.cep = 1'b0; bus.a = a2; tick(4);
      model(8'h01, a2, b1, 18'd0, 48'd0, 48'd0, 48'd0, ebc, em_hold, ep, eco);
      checks++; if (bus.p !== ep_hold) begin errors++; $display("FAIL cep_hold_p got %h want %h", bus.p, ep_hold); end
      checks++; if (bus.m !== em_hold) begin errors++; $display("FAIL cep_m_loads got %h want %h", bus.m, em_hold); end
      bus.cem = 1'b0; bus.a = a3; bus.b = b3; tick(3);
      model(8'h01, a3, b3, 18'd0, 48'd0, 48'd0, 48'd0, ebc, em, ep, eco);
      checks++; if (bus.m !== em_hold) begin errors++; $display("FAIL cem_hold_m got %h want %h", bus.m, em_hold); end
      checks++; if (bus.bcout !== ebc) begin errors++; $display("FAIL cem_bcout got %h want %h", bus.bcout, ebc); end
      checks++; if (bus.p !== ep_hold) begin errors++; $display("FAIL cep_hold_p2 got %h want %h", bus.p, ep_hold); end
      rstp = 1'b1; tick(1);
      checks++; if ({bus.p, bus.pcout} !== 96'd0) begin errors++; $display("FAIL rstp_over_cep got %h/%h want 0", bus.p, bus.pcout); end
      rstp = 1'b0; bus.cep = 1'b1; bus.cem = 1'b1; tick(3);
      checks++; if (bus.p !== ep) begin errors++; $display("FAIL ce_resume got %h want %h", bus.p, ep); end
   endtask

   initial begin
      set_rst(1'b0);
      set_ce(1'b1);
      bus.carryin = 1'b0;
      bus.bcin = 18'd0;
      drive(8'd0, 18'd0, 18'd0, 18'd0, 48'd0, 48'd0);
      #1;
      test_reset();
      test_spec_vectors();
      test_arith();
      test_latency();
      test_accumulate();
      test_ce();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
